// File: rtl/shift_seq.sv
`default_nettype none
// ============================================================================
// Module   : shift_seq
// Purpose  : Multi-pass shift sequencer for the 32-bit shifter. A shift or
//            rotate request of 0..31 positions is split into consecutive
//            passes of at most STEP_MAX positions each. The working value is
//            held in a register between passes.
// Ports    : clk, rst        - clock (rising edge), async active-high reset
//            req_valid/ready - request handshake (ready only in IDLE)
//            req_data        - 32-bit operand
//            req_amt         - total shift amount (AMT_W bits)
//            req_op          - 00 LSL, 01 ROL, 10 LSR, 11 ROR
//            resp_valid/ready- response handshake
//            resp_data       - result, held until the response handshake
//            busy            - high in RUN or DONE
// Config   : SHIFT_SEQ_RIGHT_EN - when defined, LSR/ROR are built. When
//            undefined, req_op[1] is ignored (10 -> LSL, 11 -> ROL).
// Revision : 1.0 - initial release
// ============================================================================
module shift_seq #(
  parameter int STEP_MAX = 15,
  parameter int AMT_W    = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [31:0]      req_data,
  input  logic [AMT_W-1:0] req_amt,
  input  logic [1:0]       req_op,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [31:0]      resp_data,
  output logic             busy
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [AMT_W-1:0] c_step_max = AMT_W'(STEP_MAX);

  state_t           r_state;
  state_t           w_state_next;
  logic [31:0]      r_work;
  logic [31:0]      r_resp_data;
  logic [AMT_W-1:0] r_rem;
  logic             r_op_rot;     // rotate (1) vs. logical shift (0)

  logic [AMT_W-1:0] w_step;
  logic [AMT_W-1:0] w_rem_next;
  logic [5:0]       w_inv;        // 32 - step, for the wrap-around half
  logic [31:0]      w_shift;

`ifdef SHIFT_SEQ_RIGHT_EN
  logic             r_op_right;   // direction: 1 = right
`else
  logic             w_unused_op;
  assign w_unused_op = req_op[1];
`endif

  // --------------------------------------------------------------------------
  // Per-pass datapath. step is never 0 in RUN; with step 0 the wrap-around
  // term shifts by 32 and contributes zero, so the value would be unchanged.
  // --------------------------------------------------------------------------
  assign w_step     = (r_rem > c_step_max) ? c_step_max : r_rem;
  assign w_rem_next = r_rem - w_step;
  assign w_inv      = 6'd32 - 6'(w_step);

  always_comb begin
    w_shift = r_work << w_step;
    if (r_op_rot) begin
      w_shift = (r_work << w_step) | (r_work >> w_inv);
    end
`ifdef SHIFT_SEQ_RIGHT_EN
    if (r_op_right) begin
      if (r_op_rot) begin
        w_shift = (r_work >> w_step) | (r_work << w_inv);
      end else begin
        w_shift = r_work >> w_step;
      end
    end
`endif
  end

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: next state and handshake outputs
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_next = r_state;
    req_ready    = 1'b0;
    resp_valid   = 1'b0;
    busy         = 1'b0;
    case (r_state)
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          w_state_next = (req_amt == '0) ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        busy = 1'b1;
        if (w_rem_next == '0) begin
          w_state_next = S_DONE;
        end
      end
      S_DONE: begin
        busy       = 1'b1;
        resp_valid = 1'b1;
        // Returning to IDLE here means a new request can only be taken on
        // the following edge, never on the response handshake edge itself.
        if (resp_ready) begin
          w_state_next = S_IDLE;
        end
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Working register, remaining count, op and result register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_work      <= '0;
      r_rem       <= '0;
      r_op_rot    <= 1'b0;
      r_resp_data <= '0;
`ifdef SHIFT_SEQ_RIGHT_EN
      r_op_right  <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (req_valid) begin
            r_work   <= req_data;
            r_rem    <= req_amt;
            r_op_rot <= req_op[0];
`ifdef SHIFT_SEQ_RIGHT_EN
            r_op_right <= req_op[1];
`endif
            if (req_amt == '0) begin
              r_resp_data <= req_data;
            end
          end
        end
        S_RUN: begin
          r_work <= w_shift;
          r_rem  <= w_rem_next;
          if (w_rem_next == '0) begin
            r_resp_data <= w_shift;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign resp_data = r_resp_data;

endmodule
`default_nettype wire

// File: tb/tb_shift_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_shift_seq
// Purpose  : Self-checking bench for shift_seq. Expected results come from a
//            direct (single-step) shift/rotate model and are queued when a
//            request is accepted, then compared when the response appears.
// Revision : 1.0 - initial release
// ============================================================================
module tb_shift_seq;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_data;
  logic [4:0]  req_amt;
  logic [1:0]  req_op;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_data;
  logic        busy;

  int          vectors;
  int          miscompares;
  logic [31:0] exp_q[$];

  shift_seq #(
    .STEP_MAX (15),
    .AMT_W    (5)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_data   (req_data),
    .req_amt    (req_amt),
    .req_op     (req_op),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_data  (resp_data),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: whole shift in one step, independent of pass splitting.
  function automatic logic [31:0] model(input logic [31:0] d, input int amt, input logic [1:0] op);
    logic [1:0] eop;
    eop = op;
`ifndef SHIFT_SEQ_RIGHT_EN
    eop[1] = 1'b0;
`endif
    if (amt == 0) return d;
    case (eop)
      2'b00:   return d << amt;
      2'b01:   return (d << amt) | (d >> (32 - amt));
      2'b10:   return d >> amt;
      default: return (d >> amt) | (d << (32 - amt));
    endcase
  endfunction

  function automatic int passes(input int amt);
    return (amt + 14) / 15;
  endfunction

  // Present a request for one edge (IDLE accepts it) and queue the result.
  task automatic do_req(input logic [31:0] d, input logic [4:0] a, input logic [1:0] op);
    @(negedge clk);
    req_valid = 1'b1;
    req_data  = d;
    req_amt   = a;
    req_op    = op;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    exp_q.push_back(model(d, int'(a), op));
  endtask

  // Count edges until resp_valid, bounded.
  task automatic wait_resp(output int cyc);
    cyc = 0;
    while (resp_valid !== 1'b1 && cyc < 40) begin
      @(posedge clk);
      #1;
      cyc++;
    end
  endtask

  task automatic take_resp();
    @(negedge clk);
    resp_ready = 1'b1;
    @(posedge clk);
    #1;
    resp_ready = 1'b0;
  endtask

  // Compare the queued expectation and latency for one response.
  task automatic check_one(input string name, input int exp_lat);
    int          cyc;
    logic [31:0] e;
    wait_resp(cyc);
    vectors++;
    if (cyc !== exp_lat) begin
      miscompares++;
      $display("FAIL %s latency: got %0d expected %0d", name, cyc, exp_lat);
    end
    vectors++;
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
    if (resp_data !== e) begin
      miscompares++;
      $display("FAIL %s data: got %h expected %h", name, resp_data, e);
    end
  endtask

  task automatic test_reset();
    #2;
    vectors++;
    if ({req_ready, resp_valid, busy} !== 3'b100 || resp_data !== 32'h0) begin
      miscompares++;
      $display("FAIL reset: got rdy/vld/busy=%b data=%h expected 100 data=0",
               {req_ready, resp_valid, busy}, resp_data);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_zero_amt();
    do_req(32'h8000_0001, 5'd0, 2'b00);
    vectors++;
    if (busy !== 1'b1) begin
      miscompares++;
      $display("FAIL zero_amt busy: got %b expected 1", busy);
    end
    check_one("zero_amt", 0);
    take_resp();
    vectors++;
    if (resp_valid !== 1'b0 || resp_data !== 32'h8000_0001) begin
      miscompares++;
      $display("FAIL zero_amt idle_hold: got vld=%b data=%h expected 0 80000001", resp_valid, resp_data);
    end
  endtask

  task automatic test_single_pass();
    do_req(32'h0000_00FF, 5'd4, 2'b00);
    check_one("single_pass", 1);
    take_resp();
  endtask

  task automatic test_multi_pass_hold();
    logic [31:0] held;
    do_req(32'h8000_0001, 5'd31, 2'b01);
    vectors++;
    if (exp_q[0] !== 32'hC000_0000) begin
      miscompares++;
      $display("FAIL model_rol31: got %h expected c0000000", exp_q[0]);
    end
    check_one("multi_pass", 3);
    held = resp_data;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      req_valid = 1'b1;
      req_data  = 32'h5555_AAAA;
      req_amt   = 5'd3;
      req_op    = 2'b00;
      @(posedge clk);
      #1;
      vectors++;
      if (resp_data !== held || resp_valid !== 1'b1 || req_ready !== 1'b0) begin
        miscompares++;
        $display("FAIL hold[%0d]: got data=%h vld=%b rdy=%b expected %h 1 0",
                 i, resp_data, resp_valid, req_ready, held);
      end
    end
    req_valid = 1'b0;
    take_resp();
  endtask

  task automatic test_back_to_back();
    do_req(32'hFFFF_FFFF, 5'd20, 2'b00);
    // Second request presented while the first is still running.
    req_valid = 1'b1;
    req_data  = 32'h0000_0003;
    req_amt   = 5'd1;
    req_op    = 2'b00;
    check_one("b2b_first", 2);
    take_resp();
    vectors++;
    if (resp_valid !== 1'b0 || req_ready !== 1'b1 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL b2b_handshake: got vld=%b rdy=%b busy=%b expected 0 1 0", resp_valid, req_ready, busy);
    end
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    exp_q.push_back(model(32'h0000_0003, 1, 2'b00));
    vectors++;
    if (busy !== 1'b1 || req_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL b2b_accept: got busy=%b rdy=%b expected 1 0", busy, req_ready);
    end
    check_one("b2b_second", 1);
    take_resp();
  endtask

  task automatic test_reset_mid_run();
    do_req(32'h1234_5678, 5'd31, 2'b01);
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    vectors++;
    if ({req_ready, resp_valid, busy} !== 3'b100 || resp_data !== 32'h0) begin
      miscompares++;
      $display("FAIL mid_run_reset: got rdy/vld/busy=%b data=%h expected 100 data=0",
               {req_ready, resp_valid, busy}, resp_data);
    end
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;
    do_req(32'h0000_0001, 5'd1, 2'b01);
    check_one("after_reset", 1);
    take_resp();
  endtask

  task automatic test_op_variants();
`ifdef SHIFT_SEQ_RIGHT_EN
    do_req(32'h8000_0000, 5'd31, 2'b10);
    check_one("lsr31", 3);
    take_resp();
    do_req(32'h0000_0001, 5'd16, 2'b11);
    check_one("ror16", 2);
    take_resp();
`else
    do_req(32'h0000_0001, 5'd4, 2'b10);
    check_one("op10_as_lsl", 1);
    take_resp();
`endif
    for (int i = 0; i < 8; i++) begin
      logic [31:0] d;
      logic [4:0]  a;
      logic [1:0]  op;
      d  = $urandom;
      a  = 5'($urandom_range(0, 31));
      op = 2'($urandom_range(0, 3));
      do_req(d, a, op);
      check_one("random", passes(int'(a)));
      take_resp();
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst         = 1'b1;
    req_valid   = 1'b0;
    req_data    = '0;
    req_amt     = '0;
    req_op      = '0;
    resp_ready  = 1'b0;
    test_reset();
    test_zero_amt();
    test_single_pass();
    test_multi_pass_hold();
    test_back_to_back();
    test_reset_mid_run();
    test_op_variants();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
